// File: rtl/mem_pkg.sv
// Shared encodings and constants for the memory-controller arbiter and its requesters.
package mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    COOL  = 2'd3
  } arb_state_e;

  // Load/store request fields captured at grant time.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [2:0]        len;
    logic              sgn;
  } ls_fields_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection: data wins unless a waiting fetch has been passed over STARVE_MAX times.
module mem_arb_pick #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic             ls_req_i,
  input  logic             if_req_i,
  input  logic             flush_i,
  input  logic [CNT_W-1:0] starve_cnt_i,
  output logic             grant_data_o,
  output logic             grant_fetch_o
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(STARVE_MAX);

  // A flushed fetch is never granted; data falls back in if the fetch is blocked.
  always_comb begin
    grant_data_o  = 1'b0;
    grant_fetch_o = 1'b0;
    if (ls_req_i && (starve_cnt_i < MaxCnt)) begin
      grant_data_o = 1'b1;
    end else if (if_req_i && !flush_i) begin
      grant_fetch_o = 1'b1;
    end else if (ls_req_i) begin
      grant_data_o = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported memory controller between instruction fetch and load/store,
// holding each granted request on registered strobes until the controller completes it.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic [ADDR_W-1:0] if_raddr,

  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [2:0]        ls_len,
  input  logic              ls_signed,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,

  output logic              mc_ifetch,
  output logic              mc_load,
  output logic              mc_save,
  output logic [ADDR_W-1:0] mc_iaddr,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [DATA_W-1:0] mc_wdata,
  output logic [2:0]        mc_len,
  output logic              mc_signed,

  input  logic              mc_inst_valid,
  input  logic [DATA_W-1:0] mc_inst,
  input  logic              mc_done,
  input  logic [DATA_W-1:0] mc_data
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              drop_q, drop_d;
  logic              ifetch_q, ifetch_d;
  logic              load_q, load_d;
  logic              save_q, save_d;
  logic [ADDR_W-1:0] iaddr_q, iaddr_d;
  ls_fields_t        ls_q, ls_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [ADDR_W-1:0] if_raddr_q, if_raddr_d;
  logic              ls_done_q, ls_done_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

  logic grant_data;
  logic grant_fetch;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_pick (
    .ls_req_i      (ls_req),
    .if_req_i      (if_req),
    .flush_i       (flush),
    .starve_cnt_i  (starve_q),
    .grant_data_o  (grant_data),
    .grant_fetch_o (grant_fetch)
  );

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    drop_d     = drop_q;
    ifetch_d   = ifetch_q;
    load_d     = load_q;
    save_d     = save_q;
    iaddr_d    = iaddr_q;
    ls_d       = ls_q;
    if_valid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    if_raddr_d = if_raddr_q;
    ls_done_d  = 1'b0;
    ls_rdata_d = ls_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d     = DATA;
          ls_d.we     = ls_we;
          ls_d.addr   = ls_addr;
          ls_d.wdata  = ls_wdata;
          ls_d.len    = ls_len;
          ls_d.sgn    = ls_signed;
          load_d      = !ls_we;
          save_d      = ls_we;
          // Only a fetch that is actually waiting accrues starvation credit.
          if (!if_req) begin
            starve_d = '0;
          end else if (starve_q < MaxCnt) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end else if (grant_fetch) begin
          state_d  = FETCH;
          iaddr_d  = if_addr;
          ifetch_d = 1'b1;
          starve_d = '0;
        end
      end

      // The controller cannot abort, so a flushed fetch runs out and is swallowed.
      FETCH: begin
        if (mc_inst_valid) begin
          state_d  = COOL;
          ifetch_d = 1'b0;
          drop_d   = 1'b0;
          if (!drop_q && !flush) begin
            if_valid_d = 1'b1;
            if_rdata_d = mc_inst;
            if_raddr_d = iaddr_q;
          end
        end else begin
          drop_d = drop_q | flush;
        end
      end

      DATA: begin
        if (mc_done) begin
          state_d    = COOL;
          load_d     = 1'b0;
          save_d     = 1'b0;
          ls_done_d  = 1'b1;
          ls_rdata_d = mc_data;
        end
      end

      COOL: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      drop_q     <= 1'b0;
      ifetch_q   <= 1'b0;
      load_q     <= 1'b0;
      save_q     <= 1'b0;
      iaddr_q    <= '0;
      ls_q       <= '0;
      if_valid_q <= 1'b0;
      if_rdata_q <= '0;
      if_raddr_q <= '0;
      ls_done_q  <= 1'b0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      drop_q     <= drop_d;
      ifetch_q   <= ifetch_d;
      load_q     <= load_d;
      save_q     <= save_d;
      iaddr_q    <= iaddr_d;
      ls_q       <= ls_d;
      if_valid_q <= if_valid_d;
      if_rdata_q <= if_rdata_d;
      if_raddr_q <= if_raddr_d;
      ls_done_q  <= ls_done_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign mc_ifetch = ifetch_q;
  assign mc_load   = load_q;
  assign mc_save   = save_q;
  assign mc_iaddr  = iaddr_q;
  assign mc_addr   = ls_q.addr;
  assign mc_wdata  = ls_q.wdata;
  assign mc_len    = ls_q.len;
  assign mc_signed = ls_q.sgn;

  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign if_raddr  = if_raddr_q;
  assign ls_done   = ls_done_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: the bench plays both requesters and the memory
// controller, and predicts each grant from the priority/starvation rules.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic [31:0] if_raddr;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [2:0]  ls_len = '0;
  logic        ls_signed = 1'b0;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        mc_ifetch, mc_load, mc_save;
  logic [31:0] mc_iaddr, mc_addr, mc_wdata;
  logic [2:0]  mc_len;
  logic        mc_signed;
  logic        mc_inst_valid = 1'b0;
  logic [31:0] mc_inst = '0;
  logic        mc_done = 1'b0;
  logic [31:0] mc_data = '0;

  int vecCount = 0;
  int errCount = 0;
  int starveCnt = 0;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid),
    .if_rdata(if_rdata), .if_raddr(if_raddr),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_len(ls_len), .ls_signed(ls_signed), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mc_ifetch(mc_ifetch), .mc_load(mc_load), .mc_save(mc_save),
    .mc_iaddr(mc_iaddr), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_len(mc_len), .mc_signed(mc_signed),
    .mc_inst_valid(mc_inst_valid), .mc_inst(mc_inst),
    .mc_done(mc_done), .mc_data(mc_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_pulses"}, 64'({mc_ifetch, mc_load, mc_save, if_valid, ls_done}), 64'd0);
    checkOutput({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
    checkOutput({tag, "_if_raddr"}, 64'(if_raddr), 64'd0);
    checkOutput({tag, "_ls_rdata"}, 64'(ls_rdata), 64'd0);
    checkOutput({tag, "_mc_iaddr"}, 64'(mc_iaddr), 64'd0);
    checkOutput({tag, "_mc_addr"}, 64'(mc_addr), 64'd0);
    checkOutput({tag, "_mc_wdata"}, 64'(mc_wdata), 64'd0);
    checkOutput({tag, "_mc_len_sgn"}, 64'({mc_len, mc_signed}), 64'd0);
  endtask

  task automatic newFetch(input logic [31:0] addr);
    if_req  = 1'b1;
    if_addr = addr;
  endtask

  task automatic newLs(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] len, input logic sgn);
    ls_req    = 1'b1;
    ls_we     = we;
    ls_addr   = addr;
    ls_wdata  = wdata;
    ls_len    = len;
    ls_signed = sgn;
  endtask

  // Starting in IDLE: predict and check one grant, its strobe window, response and cool-down.
  // lat = extra strobe cycles before completion; flushAt = strobe cycle carrying a flush (-1 none).
  task automatic applyStimulus(input int lat, input int flushAt, input bit flushGrant,
                               input logic [31:0] resp);
    bit          gData, gFetch, dropExp;
    logic [31:0] expAddr, expWdata;
    logic [2:0]  expLen;
    logic        expWe, expSgn;
    gData   = 1'b0;
    gFetch  = 1'b0;
    dropExp = 1'b0;
    if (ls_req && starveCnt < STARVE_MAX) gData = 1'b1;
    else if (if_req && !flushGrant) gFetch = 1'b1;
    else if (ls_req) gData = 1'b1;
    if (gData) starveCnt = if_req ? ((starveCnt < STARVE_MAX) ? starveCnt + 1 : starveCnt) : 0;
    else if (gFetch) starveCnt = 0;
    expAddr  = gFetch ? if_addr : ls_addr;
    expWdata = ls_wdata;
    expLen   = ls_len;
    expWe    = ls_we;
    expSgn   = ls_signed;
    flush = flushGrant;
    tick;
    if (flushGrant) begin
      flush  = 1'b0;
      if_req = 1'b0;
    end
    if (!gData && !gFetch) begin
      checkOutput("idle_strobes", 64'({mc_ifetch, mc_load, mc_save}), 64'd0);
      return;
    end
    for (int c = 0; c <= lat; c++) begin
      if (gFetch) begin
        checkOutput("fetch_strobe", 64'({mc_ifetch, mc_load, mc_save}), 64'd4);
        checkOutput("fetch_iaddr", 64'(mc_iaddr), 64'(expAddr));
      end else begin
        checkOutput("data_strobe", 64'({mc_ifetch, mc_load, mc_save}), 64'({1'b0, !expWe, expWe}));
        checkOutput("data_fields", 64'({mc_len, mc_signed, mc_addr}), 64'({expLen, expSgn, expAddr}));
        checkOutput("data_wdata", 64'(mc_wdata), 64'(expWdata));
      end
      checkOutput("busy_no_pulse", 64'({if_valid, ls_done}), 64'd0);
      if (c == flushAt) begin
        flush = 1'b1;
        if (gFetch) dropExp = 1'b1;
      end
      if (c == lat) begin
        if (gFetch) begin
          mc_inst_valid = 1'b1;
          mc_inst       = resp;
        end else begin
          mc_done = 1'b1;
          mc_data = resp;
        end
      end
      tick;
      if (flush) begin
        flush  = 1'b0;
        if_req = 1'b0;
      end
    end
    checkOutput("cool_strobes", 64'({mc_ifetch, mc_load, mc_save}), 64'd0);
    if (gFetch) begin
      checkOutput("if_valid", 64'(if_valid), 64'(!dropExp));
      checkOutput("ls_done_quiet", 64'(ls_done), 64'd0);
      if (!dropExp) begin
        checkOutput("if_rdata", 64'(if_rdata), 64'(resp));
        checkOutput("if_raddr", 64'(if_raddr), 64'(expAddr));
      end
      mc_inst_valid = 1'b0;
      if_req        = 1'b0;
    end else begin
      checkOutput("ls_done", 64'(ls_done), 64'd1);
      checkOutput("ls_rdata", 64'(ls_rdata), 64'(resp));
      checkOutput("if_valid_quiet", 64'(if_valid), 64'd0);
      mc_done = 1'b0;
      ls_req  = 1'b0;
    end
    tick;
    checkOutput("idle_gap", 64'({mc_ifetch, mc_load, mc_save, if_valid, ls_done}), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] len;
    int         lat, flushAt;

    rst = 1'b1;
    tick;
    tick;
    checkAllZero("reset");
    rst = 1'b0;
    tick;
    checkAllZero("post_reset");

    // Lone fetch with a slow controller.
    newFetch(32'h100);
    applyStimulus(5, -1, 1'b0, 32'h0000_0013);

    // Simultaneous requests: data first, then the held fetch.
    newFetch(32'h180);
    newLs(1'b0, 32'h2000, 32'h0, LEN_W, 1'b0);
    applyStimulus(2, -1, 1'b0, 32'hCAFE_F00D);
    applyStimulus(1, -1, 1'b0, 32'h0000_0093);

    // Continuous data traffic against a waiting fetch.
    newFetch(32'h400);
    for (int k = 0; k < STARVE_MAX + 1; k++) begin
      if (!ls_req) newLs(1'b0, 32'h3000 + 32'(k * 4), 32'h0, LEN_W, 1'b1);
      applyStimulus(1, -1, 1'b0, $urandom);
    end
    applyStimulus(0, -1, 1'b0, $urandom);

    // Flush two cycles into a fetch, then a normal fetch.
    newFetch(32'h104);
    applyStimulus(5, 1, 1'b0, 32'h1111_2222);
    newFetch(32'h200);
    applyStimulus(3, -1, 1'b0, 32'h3333_4444);

    // Flush coinciding with the controller's completion.
    newFetch(32'h208);
    applyStimulus(2, 2, 1'b0, 32'h5555_6666);

    // Store byte.
    newLs(1'b1, 32'h30000, 32'h0000_00AB, LEN_B, 1'b0);
    applyStimulus(3, -1, 1'b0, 32'h0);

    // Random traffic.
    for (int r = 0; r < 250; r++) begin
      if (!if_req && ($urandom % 3 != 0)) newFetch($urandom & 32'hFFFF_FFFC);
      if (!ls_req && ($urandom % 2 == 0)) begin
        case ($urandom % 5)
          0: len = LEN_B;
          1: len = LEN_H;
          2: len = LEN_W;
          default: len = 3'($urandom);
        endcase
        newLs(1'($urandom), $urandom, $urandom, len, 1'($urandom));
      end
      lat     = int'($urandom_range(5, 0));
      flushAt = ($urandom % 6 == 0) ? int'($urandom_range(lat, 0)) : -1;
      applyStimulus(lat, flushAt, ($urandom % 8 == 0), $urandom);
    end

    // Reset in the middle of a load abandons it silently.
    if_req = 1'b0;
    newLs(1'b0, 32'h5000, 32'h0, LEN_H, 1'b1);
    tick;
    checkOutput("pre_reset_load", 64'({mc_ifetch, mc_load, mc_save}), 64'd2);
    tick;
    rst = 1'b1;
    tick;
    checkAllZero("mid_reset");
    rst       = 1'b0;
    ls_req    = 1'b0;
    starveCnt = 0;
    tick;
    checkOutput("after_reset_idle", 64'({mc_ifetch, mc_load, mc_save, if_valid, ls_done}), 64'd0);
    newFetch(32'h800);
    applyStimulus(1, -1, 1'b0, 32'h0BAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
